// File: rtl/ahb_frame_sequencer_pkg.sv
// ahb_pkg: shared AHB transfer codes, sequencer states and command-frame field positions
package ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_BUSY = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ = 2'b11;
  localparam int HWRITE_BIT = 99;
  localparam int RSVD_BIT = 98;
  localparam int HTRANS_HI = 97;
  localparam int HTRANS_LO = 96;
  localparam int HWDATA_HI = 95;
  localparam int HWDATA_LO = 64;
  localparam int HADDR_HI = 63;
  localparam int HADDR_LO = 32;
  typedef enum logic [2:0] {IDLE, SHIFT, ADDR, DATA, RESP} state_t;
endpackage

// File: rtl/ahb_frame_sequencer_if.sv
// ahb_frame_sequencer_if: serial frame input, AHB-Lite master side and response signals
interface ahb_frame_sequencer_if;
  logic bit_valid;
  logic bit_in;
  logic frame_start;
  logic hreadyout;
  logic [31:0] hrdata;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic [1:0] htrans;
  logic hwrite;
  logic hreadyin;
  logic rsp_valid;
  logic rsp_err;
  logic [31:0] rsp_rdata;
  logic overrun;
  modport slave (
    input bit_valid, bit_in, frame_start, hreadyout, hrdata,
    output haddr, hwdata, htrans, hwrite, hreadyin, rsp_valid, rsp_err, rsp_rdata, overrun
  );
  modport master (
    output bit_valid, bit_in, frame_start, hreadyout, hrdata,
    input haddr, hwdata, htrans, hwrite, hreadyin, rsp_valid, rsp_err, rsp_rdata, overrun
  );
endinterface

// File: rtl/ahb_frame_sequencer_frame_shifter.sv
// frame_shifter: MSB-first shift register with saturating bit counter; clear+load restarts at one bit
module frame_shifter #(
  parameter int FRAME_BITS = 100,
  parameter int CNT_W = 7
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic load,
  input  logic bit_in,
  output logic [FRAME_BITS-1:0] frame,
  output logic frame_full
);
  logic [CNT_W-1:0] count;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      frame <= '0;
      count <= '0;
    end else if (clear) begin
      frame <= load ? FRAME_BITS'(bit_in) : '0;
      count <= load ? CNT_W'(1) : '0;
    end else if (load) begin
      frame <= {frame[FRAME_BITS-2:0], bit_in};
      count <= count + CNT_W'(count != CNT_W'(FRAME_BITS));
    end
  assign frame_full = count == CNT_W'(FRAME_BITS);
endmodule

// File: rtl/ahb_frame_sequencer.sv
// ahb_frame_sequencer: assembles a 100-bit command frame and runs one AHB-Lite transfer with timeout
module ahb_frame_sequencer
  import ahb_pkg::*;
#(
  parameter int FRAME_BITS = 100,
  parameter int CNT_W = 7,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic clk,
  input logic reset_n,
  ahb_frame_sequencer_if.slave bus
);
  state_t state, next;
  logic [FRAME_BITS-1:0] frame;
  logic frame_full, clear, load, frame_ok, busy, unused_bits;
  logic [7:0] wait_cnt;
  frame_shifter #(.FRAME_BITS(FRAME_BITS), .CNT_W(CNT_W)) u_shifter (
    .clk(clk), .reset_n(reset_n), .clear(clear), .load(load),
    .bit_in(bus.bit_in), .frame(frame), .frame_full(frame_full)
  );
  assign unused_bits = ^frame[HADDR_LO-1:0];
  assign frame_ok = frame[RSVD_BIT] &&
    (frame[HTRANS_HI:HTRANS_LO] == HTRANS_NONSEQ || frame[HTRANS_HI:HTRANS_LO] == HTRANS_SEQ);
  assign busy = state == ADDR || state == DATA || state == RESP;
  always_comb begin
    next = state;
    clear = 1'b0;
    load = 1'b0;
    case (state)
      IDLE: if (bus.bit_valid && bus.frame_start) begin
        clear = 1'b1;
        load = 1'b1;
        next = SHIFT;
      end
      SHIFT: if (frame_full) next = frame_ok ? ADDR : RESP;
        else if (bus.bit_valid) begin
          clear = bus.frame_start;
          load = 1'b1;
        end
      ADDR: next = bus.hreadyout ? DATA : ADDR;
      DATA: next = (bus.hreadyout || wait_cnt == 8'(TIMEOUT_CYCLES - 1)) ? RESP : DATA;
      RESP: begin
        clear = 1'b1;
        next = IDLE;
      end
      default: next = IDLE;
    endcase
  end
  assign bus.htrans = state == ADDR ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.hreadyin = state == ADDR || state == DATA;
  assign bus.rsp_valid = state == RESP;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      bus.haddr <= '0;
      bus.hwdata <= '0;
      bus.hwrite <= 1'b0;
      bus.rsp_err <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.overrun <= 1'b0;
      wait_cnt <= '0;
    end else begin
      state <= next;
      if (bus.bit_valid && busy) bus.overrun <= 1'b1;
      if (state == SHIFT && next == ADDR) begin
        bus.haddr <= frame[HADDR_HI:HADDR_LO];
        bus.hwrite <= frame[HWRITE_BIT];
        wait_cnt <= '0;
      end
      if (state == ADDR && next == DATA && bus.hwrite) bus.hwdata <= frame[HWDATA_HI:HWDATA_LO];
      if (state == DATA && !bus.hreadyout && wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'd1;
      if (state == SHIFT && next == RESP) begin
        bus.rsp_err <= 1'b1;
        bus.rsp_rdata <= '0;
      end
      if (state == DATA && next == RESP) begin
        bus.rsp_err <= !bus.hreadyout;
        bus.rsp_rdata <= (bus.hreadyout && !bus.hwrite) ? bus.hrdata : '0;
      end
    end
endmodule
